memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/trashbin_bus_pkg.sv | 22 ++
 rtl/memory_bus_arbiter_if.sv | 52 +++++
 rtl/arbiter_timeout_counter.sv | 42 ++++
 rtl/memory_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/trashbin_bus_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_e          : arbiter FSM states (IDLE, ACCESS, RESPOND)
//   req_id_e             : requester identifier (M0 = core, M1 = loader/debug)
//   TimeoutCyclesDefault : default ACCESS cycles before an error response
package trashbin_bus_pkg;

    localparam int unsigned AddrWidth            = 32;
    localparam int unsigned DataWidth            = 32;
    localparam int unsigned TimeoutCyclesDefault = 255;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2
    } arb_state_e;

    typedef enum logic {
        ReqM0 = 1'b0,
        ReqM1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Bundle of all requester-side and memory-side signals of the arbiter.
//   M0*/M1*      : requester address, store data, read/write requests, and
//                  the arbiter's ReadData/Ack/Error responses
//   AddressBus, DataWriteBus, ReadAssert, WriteAssert : memory request side
//   DataReadBus, ReadOK, WriteOK                      : memory response side
//   GrantOwner   : requester currently or last granted (0 = M0)
// Modports: slave = the arbiter, master = requesters plus memory.
interface memory_bus_arbiter_if
    import trashbin_bus_pkg::*;
;
    logic [AddrWidth-1:0] M0Address;
    logic [AddrWidth-1:0] M1Address;
    logic [DataWidth-1:0] M0WriteData;
    logic [DataWidth-1:0] M1WriteData;
    logic                 M0ReadReq;
    logic                 M1ReadReq;
    logic                 M0WriteReq;
    logic                 M1WriteReq;
    logic [DataWidth-1:0] M0ReadData;
    logic [DataWidth-1:0] M1ReadData;
    logic                 M0Ack;
    logic                 M1Ack;
    logic                 M0Error;
    logic                 M1Error;
    logic [AddrWidth-1:0] AddressBus;
    logic [DataWidth-1:0] DataWriteBus;
    logic                 ReadAssert;
    logic                 WriteAssert;
    logic [DataWidth-1:0] DataReadBus;
    logic                 ReadOK;
    logic                 WriteOK;
    logic                 GrantOwner;

    modport slave (
        input  M0Address, M1Address, M0WriteData, M1WriteData,
        input  M0ReadReq, M1ReadReq, M0WriteReq, M1WriteReq,
        output M0ReadData, M1ReadData, M0Ack, M1Ack, M0Error, M1Error,
        output AddressBus, DataWriteBus, ReadAssert, WriteAssert,
        input  DataReadBus, ReadOK, WriteOK,
        output GrantOwner
    );

    modport master (
        output M0Address, M1Address, M0WriteData, M1WriteData,
        output M0ReadReq, M1ReadReq, M0WriteReq, M1WriteReq,
        input  M0ReadData, M1ReadData, M0Ack, M1Ack, M0Error, M1Error,
        input  AddressBus, DataWriteBus, ReadAssert, WriteAssert,
        output DataReadBus, ReadOK, WriteOK,
        input  GrantOwner
    );

endinterface

// File: rtl/arbiter_timeout_counter.sv
// Counts ACCESS cycles and flags the cycle in which the timeout is reached.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clear_i   : synchronous clear (held while not in ACCESS)
//   en_i      : count this cycle (high during ACCESS)
//   expired_o : current ACCESS cycle is the Limit-th one
module arbiter_timeout_counter #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    // count_q holds the number of completed ACCESS cycles, so the Limit-th
    // cycle is the one where it equals Limit-1.
    localparam logic [7:0] LastCount = 8'(Limit - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == LastCount);

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-requester, round-robin memory bus arbiter with timeout and
// misalignment error responses.
//   CoreClock : sole clock, rising edge
//   Reset     : synchronous active-high reset
//   bus       : requester and memory signals (see memory_bus_arbiter_if)
// Flow: IDLE (arbitrate, latch winner) -> ACCESS (drive memory) ->
// RESPOND (one-cycle Ack/Error to the owner) -> IDLE.
module memory_bus_arbiter
    import trashbin_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic                 CoreClock,
    input  logic                 Reset,
    memory_bus_arbiter_if.slave  bus
);

    arb_state_e           state_q, state_d;
    req_id_e              last_q, last_d;     // round-robin pointer
    req_id_e              owner_q, owner_d;   // drives GrantOwner
    req_id_e              grant;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [DataWidth-1:0] m0_rdata_q, m0_rdata_d;
    logic [DataWidth-1:0] m1_rdata_q, m1_rdata_d;

    logic m0_req, m1_req;
    logic in_access, misaligned, ok_match, expired;

    assign m0_req     = bus.M0ReadReq | bus.M0WriteReq;
    assign m1_req     = bus.M1ReadReq | bus.M1WriteReq;
    assign in_access  = (state_q == StAccess);
    assign misaligned = (addr_q[1:0] != 2'b00);
    // Only the OK matching the latched direction completes the access.
    assign ok_match   = write_q ? bus.WriteOK : bus.ReadOK;

    arbiter_timeout_counter #(
        .Limit(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (CoreClock),
        .rst_i    (Reset),
        .clear_i  (!in_access),
        .en_i     (in_access),
        .expired_o(expired)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        err_d      = err_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        grant      = ReqM0;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        grant = req_id_e'(~last_q);
                    end else if (m1_req) begin
                        grant = ReqM1;
                    end else begin
                        grant = ReqM0;
                    end
                    last_d  = grant;
                    owner_d = grant;
                    err_d   = 1'b0;
                    state_d = StAccess;
                    // Write wins when both strobes are up on one port.
                    if (grant == ReqM1) begin
                        addr_d  = bus.M1Address;
                        wdata_d = bus.M1WriteData;
                        write_d = bus.M1WriteReq;
                    end else begin
                        addr_d  = bus.M0Address;
                        wdata_d = bus.M0WriteData;
                        write_d = bus.M0WriteReq;
                    end
                end
            end
            StAccess: begin
                if (misaligned) begin
                    err_d   = 1'b1;
                    state_d = StRespond;
                end else if (ok_match) begin
                    err_d   = 1'b0;
                    state_d = StRespond;
                    if (!write_q) begin
                        if (owner_q == ReqM1) begin
                            m1_rdata_d = bus.DataReadBus;
                        end else begin
                            m0_rdata_d = bus.DataReadBus;
                        end
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StRespond;
                    if (owner_q == ReqM1) begin
                        m1_rdata_d = '0;
                    end else begin
                        m0_rdata_d = '0;
                    end
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state_q    <= StIdle;
            last_q     <= ReqM1;  // M0 wins the first tie
            owner_q    <= ReqM0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            err_q      <= err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Bus outputs are zero outside ACCESS; strobes stay low on misalignment.
    assign bus.AddressBus   = in_access ? addr_q : '0;
    assign bus.DataWriteBus = in_access ? wdata_q : '0;
    assign bus.ReadAssert   = in_access && !misaligned && !write_q;
    assign bus.WriteAssert  = in_access && !misaligned && write_q;

    assign bus.M0Ack      = (state_q == StRespond) && (owner_q == ReqM0);
    assign bus.M1Ack      = (state_q == StRespond) && (owner_q == ReqM1);
    assign bus.M0Error    = bus.M0Ack && err_q;
    assign bus.M1Error    = bus.M1Ack && err_q;
    assign bus.M0ReadData = m0_rdata_q;
    assign bus.M1ReadData = m1_rdata_q;
    assign bus.GrantOwner = owner_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter (TIMEOUT_CYCLES = 4).
module tb_memory_bus_arbiter;

    logic CoreClock = 1'b0;
    logic Reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    memory_bus_arbiter_if bus ();

    memory_bus_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .CoreClock(CoreClock),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 CoreClock = ~CoreClock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CoreClock);
        #1;
    endtask

    task automatic drop_all();
        bus.M0ReadReq   = 1'b0;
        bus.M0WriteReq  = 1'b0;
        bus.M1ReadReq   = 1'b0;
        bus.M1WriteReq  = 1'b0;
        bus.ReadOK      = 1'b0;
        bus.WriteOK     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.M0Address   = '0;
        bus.M1Address   = '0;
        bus.M0WriteData = '0;
        bus.M1WriteData = '0;
        bus.DataReadBus = '0;
        drop_all();

        // Reset state
        step();
        step();
        Reset = 1'b0;
        check_eq("rst_grant",  {31'd0, bus.GrantOwner}, 32'd0);
        check_eq("rst_rd",     {31'd0, bus.ReadAssert}, 32'd0);
        check_eq("rst_wr",     {31'd0, bus.WriteAssert}, 32'd0);
        check_eq("rst_addr",   bus.AddressBus, 32'd0);
        check_eq("rst_ack",    {30'd0, bus.M1Ack, bus.M0Ack}, 32'd0);
        check_eq("rst_rdata0", bus.M0ReadData, 32'd0);

        // M0 read at 0x100, answered in the first ACCESS cycle
        bus.M0Address = 32'h100;
        bus.M0ReadReq = 1'b1;
        step();                               // cycle 2: ACCESS
        check_eq("rd_strobe", {31'd0, bus.ReadAssert}, 32'd1);
        check_eq("rd_addr",   bus.AddressBus, 32'h100);
        check_eq("rd_noack",  {31'd0, bus.M0Ack}, 32'd0);
        bus.ReadOK      = 1'b1;
        bus.DataReadBus = 32'hDEADBEEF;
        step();                               // cycle 3: RESPOND
        check_eq("rd_ack",    {31'd0, bus.M0Ack}, 32'd1);
        check_eq("rd_err",    {31'd0, bus.M0Error}, 32'd0);
        check_eq("rd_m1ack",  {31'd0, bus.M1Ack}, 32'd0);
        check_eq("rd_data",   bus.M0ReadData, 32'hDEADBEEF);
        check_eq("rd_strobe_off", {31'd0, bus.ReadAssert}, 32'd0);
        drop_all();
        step();
        check_eq("rd_ack_pulse", {31'd0, bus.M0Ack}, 32'd0);

        // Round robin from reset with both requesters continuously reading
        Reset = 1'b1;
        bus.M0Address   = 32'h200;
        bus.M1Address   = 32'h300;
        bus.M0ReadReq   = 1'b1;
        bus.M1ReadReq   = 1'b1;
        bus.ReadOK      = 1'b1;
        bus.DataReadBus = 32'hA5A50000;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();                           // grant edge
            check_eq($sformatf("rr_owner%0d", i), {31'd0, bus.GrantOwner}, 32'(i % 2));
            check_eq($sformatf("rr_addr%0d", i), bus.AddressBus,
                     (i % 2 == 0) ? 32'h200 : 32'h300);
            step();                           // RESPOND
            check_eq($sformatf("rr_ack%0d", i), {30'd0, bus.M1Ack, bus.M0Ack},
                     (i % 2 == 0) ? 32'd1 : 32'd2);
            step();                           // back to IDLE
        end
        drop_all();
        check_eq("rr_m1data", bus.M1ReadData, 32'hA5A50000);

        // M1 write of 0x12345678 to 0x40; WriteOK in the third ACCESS cycle,
        // a stray ReadOK must be ignored and address changes must not leak.
        bus.M1Address   = 32'h40;
        bus.M1WriteData = 32'h12345678;
        bus.M1WriteReq  = 1'b1;
        bus.ReadOK      = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("wr_strobe%0d", k), {30'd0, bus.WriteAssert, bus.ReadAssert},
                     32'd2);
            check_eq($sformatf("wr_addr%0d", k), bus.AddressBus, 32'h40);
            check_eq($sformatf("wr_data%0d", k), bus.DataWriteBus, 32'h12345678);
            check_eq($sformatf("wr_noack%0d", k), {31'd0, bus.M1Ack}, 32'd0);
            if (k == 1) bus.M1Address = 32'h44;
            if (k == 2) bus.WriteOK = 1'b1;
            step();
        end
        check_eq("wr_ack",   {30'd0, bus.M1Ack, bus.M0Ack}, 32'd2);
        check_eq("wr_err",   {31'd0, bus.M1Error}, 32'd0);
        check_eq("wr_owner", {31'd0, bus.GrantOwner}, 32'd1);
        check_eq("wr_keep_rdata", bus.M1ReadData, 32'hA5A50000);
        drop_all();
        step();

        // Silent memory: timeout after 4 ACCESS cycles
        bus.M0Address = 32'h80;
        bus.M0ReadReq = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("to_strobe%0d", k), {31'd0, bus.ReadAssert}, 32'd1);
            check_eq($sformatf("to_noack%0d", k), {31'd0, bus.M0Ack}, 32'd0);
            step();
        end
        check_eq("to_ack",   {31'd0, bus.M0Ack}, 32'd1);
        check_eq("to_err",   {31'd0, bus.M0Error}, 32'd1);
        check_eq("to_rdata", bus.M0ReadData, 32'd0);
        drop_all();
        step();

        // Misaligned M0 read at 0x102: no strobe, error response
        bus.M0Address = 32'h102;
        bus.M0ReadReq = 1'b1;
        bus.ReadOK    = 1'b1;
        step();
        check_eq("mis_strobe", {30'd0, bus.WriteAssert, bus.ReadAssert}, 32'd0);
        check_eq("mis_noack",  {31'd0, bus.M0Ack}, 32'd0);
        step();
        check_eq("mis_ack",    {31'd0, bus.M0Ack}, 32'd1);
        check_eq("mis_err",    {31'd0, bus.M0Error}, 32'd1);
        check_eq("mis_strobe2", {30'd0, bus.WriteAssert, bus.ReadAssert}, 32'd0);
        drop_all();
        step();
        check_eq("mis_idle_ack", {31'd0, bus.M0Ack}, 32'd0);

        // Reset mid-ACCESS; read+write together on M1 acts as a write
        bus.M1Address   = 32'h40;
        bus.M1ReadReq   = 1'b1;
        bus.M1WriteReq  = 1'b1;
        step();
        check_eq("mr_strobe", {30'd0, bus.WriteAssert, bus.ReadAssert}, 32'd2);
        check_eq("mr_owner",  {31'd0, bus.GrantOwner}, 32'd1);
        Reset = 1'b1;
        step();
        check_eq("mr_strobe_off", {30'd0, bus.WriteAssert, bus.ReadAssert}, 32'd0);
        check_eq("mr_noack",      {30'd0, bus.M1Ack, bus.M0Ack}, 32'd0);
        check_eq("mr_owner_rst",  {31'd0, bus.GrantOwner}, 32'd0);
        check_eq("mr_rdata_rst",  bus.M1ReadData, 32'd0);
        Reset = 1'b0;
        drop_all();
        step();
        check_eq("mr_noack2", {30'd0, bus.M1Ack, bus.M0Ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
